hazard_ctrl_unit: RTL

//  Pipeline hazard controller for the 5-stage RV32I core; next generation of the load-use detector.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_reg_match.sv | 16 +
 rtl/hazard_ctrl_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared decode helpers and state type for the pipeline hazard controller.
// Pure combinational field slicing; no latency, no flow control.
package hazard_pkg;

   localparam logic [6:0] OPC_LOAD = 7'h03;

   typedef enum logic {RUN, LSTALL} hz_state_e;

   function automatic logic [4:0] inst_rs1(input logic [31:0] inst);
      return inst[19:15];
   endfunction

   function automatic logic [4:0] inst_rs2(input logic [31:0] inst);
      return inst[24:20];
   endfunction

   function automatic logic [4:0] inst_rd(input logic [31:0] inst);
      return inst[11:7];
   endfunction

   function automatic logic [6:0] inst_opcode(input logic [31:0] inst);
      return inst[6:0];
   endfunction

endpackage

// File: rtl/hazard_reg_match.sv
// Flags when a writing stage's rd feeds a source register read in ID.
// Combinational, zero latency; no backpressure. x0 never matches.
module hazard_reg_match (
   input  logic [4:0] rd,
   input  logic       wren,
   input  logic [4:0] rs1,
   input  logic       rs1_en,
   input  logic [4:0] rs2,
   input  logic       rs2_en,
   output logic       match
);

   assign match = wren && (rd != 5'd0) &&
                  ((rs1_en && (rd == rs1)) || (rs2_en && (rd == rs2)));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: PC/stage enables and flushes, multi-cycle load-use stall, stall counter.
// Outputs are combinational from state and inputs; a dmem wait freezes the whole pipe and the FSM.
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int RF_BYPASS         = 1,
   parameter int CNT_W             = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [31:0]      i_ID_inst,
   input  logic             i_rs1_en,
   input  logic             i_rs2_en,
   input  logic [31:0]      i_EX_inst,
   input  logic             i_EX_rd_wren,
   input  logic             i_EX_redirect,
   input  logic [31:0]      i_WB_inst,
   input  logic             i_WB_rd_wren,
   input  logic             i_dmem_req,
   input  logic             i_dmem_ready,
   output logic             o_pc_en,
   output logic             o_IF_ID_stall,
   output logic             o_IF_ID_flush,
   output logic             o_ID_EX_stall,
   output logic             o_ID_EX_flush,
   output logic             o_EX_MEM_stall,
   output logic             o_MEM_WB_flush,
   output logic [CNT_W-1:0] o_stall_cnt
);

   localparam logic [2:0] LOAD_HOLD = 3'(LOAD_STALL_CYCLES - 1);

   hz_state_e  state, state_nx;
   logic [2:0] cnt, cnt_nx;
   logic       ex_match, wb_match;
   logic       load_use, wb_haz, mem_wait;

   hazard_reg_match u_ex_match (
      .rd     (inst_rd(i_EX_inst)),
      .wren   (i_EX_rd_wren),
      .rs1    (inst_rs1(i_ID_inst)),
      .rs1_en (i_rs1_en),
      .rs2    (inst_rs2(i_ID_inst)),
      .rs2_en (i_rs2_en),
      .match  (ex_match)
   );

   hazard_reg_match u_wb_match (
      .rd     (inst_rd(i_WB_inst)),
      .wren   (i_WB_rd_wren),
      .rs1    (inst_rs1(i_ID_inst)),
      .rs1_en (i_rs1_en),
      .rs2    (inst_rs2(i_ID_inst)),
      .rs2_en (i_rs2_en),
      .match  (wb_match)
   );

   assign load_use = ex_match && (inst_opcode(i_EX_inst) == OPC_LOAD);
   assign wb_haz   = (RF_BYPASS == 0) && wb_match;
   assign mem_wait = i_dmem_req && !i_dmem_ready;

   // Only the register and opcode fields take part in hazard decisions.
   logic unused_bits;
   assign unused_bits = ^{i_ID_inst[31:25], i_ID_inst[14:0], i_EX_inst[31:12],
                          i_WB_inst[31:12], i_WB_inst[6:0]};

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state       <= RUN;
         cnt         <= 3'd0;
         o_stall_cnt <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (!o_pc_en && (o_stall_cnt != {CNT_W{1'b1}}))
            o_stall_cnt <= o_stall_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (!mem_wait) begin
         if (i_EX_redirect) begin
            state_nx = RUN;
            cnt_nx   = 3'd0;
         end else if (state == LSTALL) begin
            if (cnt == 3'd1) begin
               state_nx = RUN;
               cnt_nx   = 3'd0;
            end else begin
               cnt_nx = cnt - 3'd1;
            end
         end else if (load_use && (LOAD_STALL_CYCLES > 1)) begin
            // The RUN cycle that detects the hazard is the first bubble.
            state_nx = LSTALL;
            cnt_nx   = LOAD_HOLD;
         end
      end
   end

   always_comb begin
      o_pc_en        = 1'b1;
      o_IF_ID_stall  = 1'b0;
      o_IF_ID_flush  = 1'b0;
      o_ID_EX_stall  = 1'b0;
      o_ID_EX_flush  = 1'b0;
      o_EX_MEM_stall = 1'b0;
      o_MEM_WB_flush = 1'b0;
      if (mem_wait) begin
         o_pc_en        = 1'b0;
         o_IF_ID_stall  = 1'b1;
         o_ID_EX_stall  = 1'b1;
         o_EX_MEM_stall = 1'b1;
         o_MEM_WB_flush = 1'b1;
      end else if (i_EX_redirect) begin
         o_IF_ID_flush = 1'b1;
         o_ID_EX_flush = 1'b1;
      end else if ((state == LSTALL) || load_use || wb_haz) begin
         o_pc_en       = 1'b0;
         o_IF_ID_stall = 1'b1;
         o_ID_EX_flush = 1'b1;
      end
   end

endmodule
